instr_fetch: RTL and testbench

//  Program-counter / fetch stage that sits directly upstream of Rom in the single-cycle core.
//  - Drives the Rom word address and captures the returned instruction into a fetch register.
//  - Presents the instruction to decode with its PC and a valid flag.
//  - Handles stall, branch/jump redirect, and the post-reset wait for ClockGenerator lock.

---
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC / fetch stage ahead of a combinational-read Rom. Holds in BOOT
//            until clock lock, then fetches one instruction per cycle with
//            stall and redirect. Optional macro IFETCH_HALT_ON_WRAP_EN stops
//            fetch after the last Rom word instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int unsigned                 AddrWidth = 5,
  parameter int unsigned                 DataWidth = 32,
  parameter logic [AddrWidth-1:0]        ResetPc   = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 locked,
  output logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] data,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [AddrWidth-1:0] redirect_target,
  output logic [DataWidth-1:0] instr,
  output logic [AddrWidth-1:0] instr_pc,
  output logic                 instr_valid,
  output logic                 halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] pc_q;
  logic [DataWidth-1:0] instr_q;
  logic [AddrWidth-1:0] instr_pc_q;
  logic                 instr_valid_q;
  logic                 halted_q;
  logic [AddrWidth-1:0] pc_inc_d;

  assign pc_inc_d = pc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= ResetPc;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          if (locked) state_q <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_q          <= redirect_target;
            instr_valid_q <= 1'b0;
          end else if (!stall) begin
            instr_q       <= data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
`ifdef IFETCH_HALT_ON_WRAP_EN
            // Last Rom word: keep the PC parked on it instead of wrapping.
            if (pc_q == {AddrWidth{1'b1}}) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_inc_d;
            end
`else
            pc_q <= pc_inc_d;
`endif
          end
        end
`ifdef IFETCH_HALT_ON_WRAP_EN
        HALT: begin
          instr_valid_q <= 1'b0;
          if (redirect_valid) begin
            pc_q     <= redirect_target;
            halted_q <= 1'b0;
            state_q  <= RUN;
          end
        end
`endif
        default: state_q <= BOOT;
      endcase
    end
  end

  assign addr        = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
`ifdef IFETCH_HALT_ON_WRAP_EN
  assign halted      = halted_q;
`else
  assign halted      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch with a Rom model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          locked;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.AddrWidth(AW), .DataWidth(DW), .ResetPc('0)) dut (
    .clk             (clk),
    .reset           (reset),
    .locked          (locked),
    .addr            (addr),
    .data            (data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted)
  );

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ ({27'd0, a} * 32'h0001_0003);
  endfunction

  assign data = rom(addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [AW-1:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, {27'd0, instr_pc}, {27'd0, pc});
    check({tag, "_instr"}, instr, rom(pc));
  endtask

  initial begin
    reset = 1'b1; locked = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;

    // Reset, then BOOT with lock low for three cycles
    step();
    check("rst_addr", {27'd0, addr}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", {27'd0, instr_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("boot_addr", {27'd0, addr}, 32'd0);
      check("boot_valid", {31'd0, instr_valid}, 32'd0);
    end
    locked = 1'b1;
    step();
    check("lock_valid", {31'd0, instr_valid}, 32'd0);
    check("lock_addr", {27'd0, addr}, 32'd0);
    step();
    check_fetch("first", 5'd0);
    check("first_addr", {27'd0, addr}, 32'd1);

    // Free run up to instr_pc 3 (addr 4)
    for (int k = 1; k <= 3; k++) begin
      step();
      check_fetch("run", k[AW-1:0]);
    end

    // Stall three cycles at PC 4
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", {27'd0, addr}, 32'd4);
      check_fetch("stall", 5'd3);
    end
    stall = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      step();
      check_fetch("resume", k[AW-1:0]);
    end

    // Redirect to 0x10 while stalled at PC 7
    check("pre_redir_addr", {27'd0, addr}, 32'd7);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 5'h10;
    step();
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_addr", {27'd0, addr}, 32'h10);
    check("redir_pc_hold", {27'd0, instr_pc}, 32'd6);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    check_fetch("post_redir", 5'h10);
    check("post_redir_addr", {27'd0, addr}, 32'h11);

    // Run to the top of the Rom
    for (int k = 17; k <= 31; k++) begin
      step();
      check_fetch("top", k[AW-1:0]);
    end
`ifdef IFETCH_HALT_ON_WRAP_EN
    check("top_addr", {27'd0, addr}, 32'd31);
    stall = 1'b1;
    step();
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_addr", {27'd0, addr}, 32'd31);
    stall = 1'b0; redirect_valid = 1'b1; redirect_target = 5'd2;
    step();
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    check("unhalt_valid", {31'd0, instr_valid}, 32'd0);
    check("unhalt_addr", {27'd0, addr}, 32'd2);
    redirect_valid = 1'b0;
    step();
    check_fetch("after_halt", 5'd2);
`else
    check("wrap_addr", {27'd0, addr}, 32'd0);
    step();
    check_fetch("wrap", 5'd0);
    check("wrap_halted", {31'd0, halted}, 32'd0);
    // Losing lock in RUN must not stop fetch
    locked = 1'b0;
    step();
    check_fetch("unlock_run", 5'd1);
    locked = 1'b1;
`endif

    // Advance to PC 9, then reset together with a redirect
    for (int i = 0; i < 40 && addr != 5'd9; i++) step();
    check("reach_pc9", {27'd0, addr}, 32'd9);
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 5'd20;
    step();
    check("mid_rst_addr", {27'd0, addr}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_pc", {27'd0, instr_pc}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0; redirect_valid = 1'b0;
    step();
    check("reboot_valid", {31'd0, instr_valid}, 32'd0);
    check("reboot_addr", {27'd0, addr}, 32'd0);
    step();
    check_fetch("reboot_first", 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
